// File: rtl/stress_acc_scheduler.sv
// Job scheduler for the stress-detection accelerator: soft-resets and launches
// the KNN/SVM engines, watches them with a watchdog and returns one result.
module stress_acc_scheduler #(
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int COMBINE_AND = 1
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_mode,
    input  logic                 cmd_seq,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic                 knn_rst_n,
    output logic                 svm_rst_n,
    output logic                 knn_start,
    output logic                 svm_start,
    input  logic                 knn_done,
    input  logic                 knn_class,
    input  logic                 svm_done,
    input  logic                 svm_class,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 result_class,
    output logic                 result_knn,
    output logic                 result_svm,
    output logic [1:0]           result_status,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERST   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NONE = 2'b01;
    localparam logic [1:0] ST_KTMO = 2'b10;
    localparam logic [1:0] ST_STMO = 2'b11;

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

    logic [2:0]           state;
    logic [2:0]           state_d;
    logic [CW-1:0]        rcnt;
    logic [1:0]           mode_q;
    logic                 seq_q;
    logic                 phase_q;
    logic [TIMEOUT_W-1:0] wd;
    logic [TIMEOUT_W-1:0] wd_inc;
    logic                 knn_got;
    logic                 knn_cls;
    logic                 svm_got;
    logic                 svm_cls;
    logic                 abort_knn;
    logic                 abort_svm;
    logic [1:0]           status_q;

    logic accept;
    logic rst_last;
    logic knn_act;
    logic svm_act;
    logic knn_hit;
    logic svm_hit;
    logic knn_ok;
    logic svm_ok;
    logic all_ok;
    logic tmo;
    logic seq_next;
    logic comb_cls;
    logic sel_cls;

    assign accept   = (state == S_IDLE) && cmd_valid;
    assign rst_last = (rcnt == RST_LAST);

    // In sequential mode phase 0 runs KNN only, phase 1 runs SVM only.
    assign knn_act = mode_q[0] && !(seq_q && phase_q);
    assign svm_act = mode_q[1] && !(seq_q && !phase_q);

    assign knn_hit = knn_act && !knn_got && knn_done;
    assign svm_hit = svm_act && !svm_got && svm_done;
    assign knn_ok  = !knn_act || knn_got || knn_hit;
    assign svm_ok  = !svm_act || svm_got || svm_hit;
    assign all_ok  = knn_ok && svm_ok;

    assign wd_inc = (wd >= timeout_limit) ? wd : wd + TIMEOUT_W'(1);
    assign tmo    = (timeout_limit != '0) && (wd_inc == timeout_limit);

    assign seq_next = seq_q && !phase_q;

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_d = (cmd_mode == 2'b00) ? S_RESP : S_ERST;
            end
            S_ERST: begin
                if (rst_last)
                    state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (all_ok)
                    state_d = seq_next ? S_LAUNCH : S_RESP;
                else if (tmo)
                    state_d = S_ABORT;
            end
            S_ABORT: begin
                if (rst_last)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (result_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_d;
            if (state_d != state)
                rcnt <= '0;
            else if (state == S_ERST || state == S_ABORT)
                rcnt <= rcnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mode_q  <= 2'b00;
            seq_q   <= 1'b0;
            phase_q <= 1'b0;
        end else if (accept) begin
            mode_q  <= cmd_mode;
            seq_q   <= cmd_seq && (cmd_mode == 2'b11);
            phase_q <= 1'b0;
        end else if (state == S_WAIT && all_ok && seq_next) begin
            phase_q <= 1'b1;
        end
    end

    // Watchdog restarts for every launch phase and never wraps.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            wd <= '0;
        else if (accept || state == S_LAUNCH)
            wd <= '0;
        else if (state == S_WAIT)
            wd <= wd_inc;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            knn_got <= 1'b0;
            knn_cls <= 1'b0;
            svm_got <= 1'b0;
            svm_cls <= 1'b0;
        end else if (accept) begin
            knn_got <= 1'b0;
            knn_cls <= 1'b0;
            svm_got <= 1'b0;
            svm_cls <= 1'b0;
        end else if (state == S_WAIT) begin
            if (knn_hit) begin
                knn_got <= 1'b1;
                knn_cls <= knn_class;
            end
            if (svm_hit) begin
                svm_got <= 1'b1;
                svm_cls <= svm_class;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            abort_knn <= 1'b0;
            abort_svm <= 1'b0;
            status_q  <= ST_OK;
        end else if (accept) begin
            abort_knn <= 1'b0;
            abort_svm <= 1'b0;
            status_q  <= (cmd_mode == 2'b00) ? ST_NONE : ST_OK;
        end else if (state == S_WAIT && !all_ok && tmo) begin
            abort_knn <= !knn_ok;
            abort_svm <= !svm_ok;
            status_q  <= !knn_ok ? ST_KTMO : ST_STMO;
        end
    end

    assign comb_cls = (COMBINE_AND != 0) ? (knn_cls & svm_cls)
                                         : (knn_cls | svm_cls);

    always_comb begin
        sel_cls = 1'b0;
        unique case (mode_q)
            2'b01:   sel_cls = knn_cls;
            2'b10:   sel_cls = svm_cls;
            2'b11:   sel_cls = comb_cls;
            default: sel_cls = 1'b0;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    assign knn_rst_n = !((state == S_ERST && mode_q[0])
                      || (state == S_ABORT && abort_knn));
    assign svm_rst_n = !((state == S_ERST && mode_q[1])
                      || (state == S_ABORT && abort_svm));

    assign knn_start = (state == S_LAUNCH) && knn_act;
    assign svm_start = (state == S_LAUNCH) && svm_act;

    assign result_valid  = (state == S_RESP);
    assign result_class  = result_valid && (status_q == ST_OK) && sel_cls;
    assign result_knn    = result_valid && knn_cls;
    assign result_svm    = result_valid && svm_cls;
    assign result_status = result_valid ? status_q : ST_OK;

endmodule

// File: tb/tb_stress_acc_scheduler.sv
// Scoreboard bench for stress_acc_scheduler: behavioural engines, a job-level
// reference model, and a monitor that checks every returned result.
module tb_stress_acc_scheduler;

    localparam int RC    = 2;
    localparam int TW    = 16;
    localparam int NEVER = 1000;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_mode = 2'b00;
    logic          cmd_seq = 1'b0;
    logic [TW-1:0] timeout_limit = '0;
    logic          knn_done, knn_class, svm_done, svm_class;
    logic          result_ready = 1'b0;

    logic       cmd_ready, knn_rst_n, svm_rst_n, knn_start, svm_start;
    logic       result_valid, result_class, result_knn, result_svm, busy;
    logic [1:0] result_status;

    logic       o_cmd_ready, o_knn_rst_n, o_svm_rst_n, o_knn_start;
    logic       o_svm_start, o_result_valid, o_result_class, o_result_knn;
    logic       o_result_svm, o_busy;
    logic [1:0] o_result_status;

    always #5 CLK = ~CLK;

    stress_acc_scheduler #(.RST_CYCLES(RC), .TIMEOUT_W(TW), .COMBINE_AND(1)) u_dut (
        .CLK(CLK), .RESETn(RESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_seq(cmd_seq),
        .timeout_limit(timeout_limit),
        .knn_rst_n(knn_rst_n), .svm_rst_n(svm_rst_n),
        .knn_start(knn_start), .svm_start(svm_start),
        .knn_done(knn_done), .knn_class(knn_class),
        .svm_done(svm_done), .svm_class(svm_class),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_knn(result_knn),
        .result_svm(result_svm), .result_status(result_status),
        .busy(busy)
    );

    // Same stimulus, OR combine rule.
    stress_acc_scheduler #(.RST_CYCLES(RC), .TIMEOUT_W(TW), .COMBINE_AND(0)) u_or (
        .CLK(CLK), .RESETn(RESETn),
        .cmd_valid(cmd_valid), .cmd_ready(o_cmd_ready),
        .cmd_mode(cmd_mode), .cmd_seq(cmd_seq),
        .timeout_limit(timeout_limit),
        .knn_rst_n(o_knn_rst_n), .svm_rst_n(o_svm_rst_n),
        .knn_start(o_knn_start), .svm_start(o_svm_start),
        .knn_done(knn_done), .knn_class(knn_class),
        .svm_done(svm_done), .svm_class(svm_class),
        .result_valid(o_result_valid), .result_ready(result_ready),
        .result_class(o_result_class), .result_knn(o_result_knn),
        .result_svm(o_result_svm), .result_status(o_result_status),
        .busy(o_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_jobs = 0;
    int hold_n = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural engines: done rises kd/sd cycles after start, then is noisy.
    int kd = 1, sd = 1, kcnt = 0, scnt = 0;
    bit kc = 0, sc = 0, krun = 0, srun = 0;
    logic [3:0] nz = '0;

    always @(posedge CLK) begin
        nz <= 4'($urandom);
        if (!RESETn || !knn_rst_n) begin
            krun <= 0; kcnt <= 0;
        end else if (knn_start) begin
            krun <= 1; kcnt <= 1;
        end else if (krun && kcnt < 100000) kcnt <= kcnt + 1;
        if (!RESETn || !svm_rst_n) begin
            srun <= 0; scnt <= 0;
        end else if (svm_start) begin
            srun <= 1; scnt <= 1;
        end else if (srun && scnt < 100000) scnt <= scnt + 1;
    end

    assign knn_done  = krun && (kcnt == kd || (kcnt > kd && nz[0]));
    assign knn_class = (krun && kcnt == kd) ? kc : nz[1];
    assign svm_done  = srun && (scnt == sd || (scnt > sd && nz[2]));
    assign svm_class = (srun && scnt == sd) ? sc : nz[3];

    typedef struct {
        int acc;
        int lat;
        int st;
        int cls_and;
        int cls_or;
        int rk;
        int rs;
        int ks;
        int ss;
        int kr;
        int sr;
    } exp_t;

    exp_t q[$];

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Job-level prediction from delays, limit and classes.
    function automatic exp_t predict(input int mode, input bit seq, input int lim,
                                     input int dk, input int ds,
                                     input bit ck, input bit cs);
        exp_t e;
        bit uk, us, gk, gs, kok, sok;
        e = '{default: 0};
        uk = mode[0]; us = mode[1]; gk = 0; gs = 0;
        if (mode == 0) begin
            e.st = 1; e.lat = 1;
        end else if (!(seq && mode == 3)) begin
            kok = !uk || lim == 0 || dk <= lim;
            sok = !us || lim == 0 || ds <= lim;
            e.ks = uk; e.ss = us;
            e.kr = uk ? RC : 0; e.sr = us ? RC : 0;
            if (kok && sok) begin
                gk = uk; gs = us; e.st = 0;
                e.lat = RC + 2 + imax(uk ? dk : 0, us ? ds : 0);
            end else begin
                gk = uk && dk <= lim; gs = us && ds <= lim;
                e.st = (uk && !gk) ? 2 : 3;
                e.lat = 2 * RC + 2 + lim;
                if (uk && !gk) e.kr += RC;
                if (us && !gs) e.sr += RC;
            end
        end else begin
            e.ks = 1; e.kr = RC; e.sr = RC;
            if (lim != 0 && dk > lim) begin
                e.st = 2; e.lat = 2 * RC + 2 + lim; e.kr += RC;
            end else begin
                gk = 1; e.ss = 1;
                if (lim != 0 && ds > lim) begin
                    e.st = 3; e.lat = 2 * RC + 3 + dk + lim; e.sr += RC;
                end else begin
                    gs = 1; e.st = 0; e.lat = RC + 3 + dk + ds;
                end
            end
        end
        e.rk = gk ? ck : 0;
        e.rs = gs ? cs : 0;
        if (e.st == 0) begin
            e.cls_and = (mode == 1) ? ck : (mode == 2) ? cs : (ck & cs);
            e.cls_or  = (mode == 1) ? ck : (mode == 2) ? cs : (ck | cs);
        end
        return e;
    endfunction

    // Consumer: hold ready low for hold_n cycles of each response, then random.
    int low_cnt = 0;
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (!result_valid) begin
                low_cnt = 0; result_ready = 0;
            end else if (low_cnt < hold_n) begin
                low_cnt++; result_ready = 0;
            end else begin
                result_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops an expectation on each new result and checks stability.
    initial begin
        exp_t e;
        bit in_resp;
        int ks_c, ss_c, kr_c, sr_c;
        logic [4:0] snap;
        in_resp = 0; ks_c = 0; ss_c = 0; kr_c = 0; sr_c = 0; snap = '0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                in_resp = 0; ks_c = 0; ss_c = 0; kr_c = 0; sr_c = 0;
                continue;
            end
            if (!knn_rst_n) kr_c++;
            if (!svm_rst_n) sr_c++;
            if (knn_start) ks_c++;
            if (svm_start) ss_c++;
            if (result_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc - e.acc + 1, e.lat);
                        chk("status", result_status, e.st);
                        chk("class_and", result_class, e.cls_and);
                        chk("or_valid", o_result_valid, 1);
                        chk("class_or", o_result_class, e.cls_or);
                        chk("result_knn", result_knn, e.rk);
                        chk("result_svm", result_svm, e.rs);
                        chk("knn_starts", ks_c, e.ks);
                        chk("svm_starts", ss_c, e.ss);
                        chk("knn_rst_low", kr_c, e.kr);
                        chk("svm_rst_low", sr_c, e.sr);
                    end
                    ks_c = 0; ss_c = 0; kr_c = 0; sr_c = 0;
                    snap = {result_class, result_knn, result_svm, result_status};
                    in_resp = 1;
                end else begin
                    chk("resp_stable",
                        {result_class, result_knn, result_svm, result_status}, snap);
                end
                chk("resp_cmd_ready", cmd_ready, 0);
                chk("resp_busy", busy, 1);
                if (result_ready) begin
                    in_resp = 0;
                    done_cnt++;
                end
            end else if (in_resp) begin
                chk("valid_dropped", 0, 1);
                in_resp = 0;
            end
        end
    end

    task automatic issue(input int mode, input bit seq, input int lim,
                         input int dk, input int ds, input bit ck, input bit cs,
                         input bit push, input int hold);
        exp_t e;
        @(negedge CLK);
        kd = dk; sd = ds; kc = ck; sc = cs; hold_n = hold;
        timeout_limit = TW'(lim);
        cmd_mode = 2'(mode); cmd_seq = seq; cmd_valid = 1;
        @(posedge CLK);
        #1;
        if (push) begin
            e = predict(mode, seq, lim, dk, ds, ck, cs);
            e.acc = cyc;
            q.push_back(e);
            exp_jobs++;
        end
        // Garbage command while busy must be ignored.
        cmd_mode = 2'($urandom); cmd_seq = 1'($urandom);
        @(posedge CLK);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_jobs();
        int n;
        n = 0;
        while (done_cnt < exp_jobs && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (done_cnt < exp_jobs) chk("job_complete", done_cnt, exp_jobs);
    endtask

    task automatic run_job(input int mode, input bit seq, input int lim,
                           input int dk, input int ds, input bit ck, input bit cs,
                           input int hold);
        issue(mode, seq, lim, dk, ds, ck, cs, 1, hold);
        wait_jobs();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int mode, lim, dk, ds;
        bit seq;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_knn_rst_n", knn_rst_n, 1);
        chk("rst_svm_rst_n", svm_rst_n, 1);
        chk("rst_starts", {knn_start, svm_start}, 0);
        chk("rst_status", result_status, 0);
        @(negedge CLK);
        RESETn = 1;
        repeat (2) @(negedge CLK);

        run_job(1, 0, 0, 7, 1, 1, 0, 0);
        run_job(3, 0, 0, 5, 5, 1, 0, 0);
        run_job(3, 1, 0, 3, 5, 1, 1, 0);
        run_job(2, 0, 5, 1, NEVER, 0, 1, 0);
        run_job(2, 0, 5, 1, 5, 0, 1, 0);
        run_job(0, 0, 0, 1, 1, 1, 1, 4);
        run_job(3, 0, 4, NEVER, NEVER, 1, 1, 1);
        run_job(3, 0, 4, 2, NEVER, 1, 1, 0);
        run_job(3, 1, 6, 7, 2, 1, 1, 0);
        run_job(3, 1, 6, 6, 7, 1, 0, 2);
        run_job(1, 0, 3, 4, 1, 1, 0, 0);

        // Reset in the middle of a job: aborts silently.
        issue(1, 0, 0, NEVER, 1, 1, 0, 0, 0);
        repeat (6) @(negedge CLK);
        #1;
        RESETn = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_knn_rst_n", knn_rst_n, 1);
        @(negedge CLK);
        #1;
        RESETn = 1;
        run_job(1, 0, 0, 4, 1, 1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 3);
            seq = 1'($urandom);
            lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            dk = ($urandom_range(0, 6) == 0 && lim != 0) ? NEVER : $urandom_range(1, 14);
            ds = ($urandom_range(0, 6) == 0 && lim != 0) ? NEVER : $urandom_range(1, 14);
            run_job(mode, seq, lim, dk, ds, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3));
        end

        repeat (5) @(negedge CLK);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
